light_result_monitor: RTL and testbench

//  Far end of LightSeparatorInterface: the stimulus side drives the separator,
//  and this block captures the separator's classified output stream.

---
 rtl/light_result_monitor.sv | 127 ++++++++++++
 tb/tb_light_result_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/light_result_monitor.sv
// Result monitor: captures classified separator results into a FIFO and
// keeps saturating per-class hit counters plus a backpressure stall counter.

module light_result_monitor_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt_q <= '0;
    else if (clr_i)                 cnt_q <= '0;
    else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

module light_result_monitor #(
  parameter int DATA_W  = 8,
  parameter int CLASS_W = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  localparam int NCLASS = 2**CLASS_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               out_valid,
  input  logic [CLASS_W-1:0] out_class,
  input  logic [DATA_W-1:0]  out_data,
  output logic               out_ready,
  input  logic               rd_req,
  output logic               rd_valid,
  output logic [CLASS_W-1:0] rd_class,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_err,
  output logic [LVL_W-1:0]   level,
  input  logic [CLASS_W-1:0] cnt_sel,
  output logic [CNT_W-1:0]   cnt_value,
  output logic [CNT_W-1:0]   stall_cnt,
  input  logic               clr
);
  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t                         mem_q [DEPTH];
  logic   [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic   [LVL_W-1:0]             level_q, level_d;
  logic                           rd_valid_q, rd_err_q;
  entry_t                         rd_ent_q;
  logic   [NCLASS-1:0][CNT_W-1:0] cls_cnt;
  logic                           accept, pop, empty;

  // Ready comes only from registered occupancy, so a pop at full cannot
  // open a write slot in the same cycle.
  assign out_ready = (level_q != LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign accept    = out_valid & out_ready;
  assign pop       = rd_req & ~empty;

  always_comb begin
    level_d = level_q;
    case ({accept, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= '{cls: out_class, data: out_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_ent_q   <= '0;
    end else begin
      level_q    <= level_d;
      rd_valid_q <= pop;
      rd_err_q   <= rd_req & empty;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_ent_q <= mem_q[rd_ptr_q];
      end
    end
  end

  for (genvar c = 0; c < NCLASS; c++) begin : g_cls
    light_result_monitor_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .inc_i (accept && out_class == CLASS_W'(c)),
      .cnt_o (cls_cnt[c])
    );
  end

  light_result_monitor_cnt #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .inc_i (out_valid & ~out_ready),
    .cnt_o (stall_cnt)
  );

  assign cnt_value = cls_cnt[cnt_sel];
  assign level     = level_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign rd_class  = rd_ent_q.cls;
  assign rd_data   = rd_ent_q.data;
endmodule

// File: tb/tb_light_result_monitor.sv
// Directed bench for light_result_monitor: ordering, full/stall, empty pop,
// concurrent wrap, clear priority and counter saturation (second instance).

module tb_light_result_monitor;
  logic       clk = 1'b0;
  logic       rst;
  logic       out_valid, rd_req, clr;
  logic [1:0] out_class, cnt_sel;
  logic [7:0] out_data;

  logic        out_ready, rd_valid, rd_err;
  logic [1:0]  rd_class;
  logic [7:0]  rd_data;
  logic [3:0]  level;
  logic [15:0] cnt_value, stall_cnt;

  logic        s_out_ready, s_rd_valid, s_rd_err;
  logic [1:0]  s_rd_class;
  logic [7:0]  s_rd_data;
  logic [3:0]  s_level;
  logic [3:0]  s_cnt_value, s_stall_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  light_result_monitor u_dut (
    .clk(clk), .rst(rst), .out_valid(out_valid), .out_class(out_class),
    .out_data(out_data), .out_ready(out_ready), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_class(rd_class), .rd_data(rd_data),
    .rd_err(rd_err), .level(level), .cnt_sel(cnt_sel),
    .cnt_value(cnt_value), .stall_cnt(stall_cnt), .clr(clr)
  );

  light_result_monitor #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .out_valid(out_valid), .out_class(out_class),
    .out_data(out_data), .out_ready(s_out_ready), .rd_req(rd_req),
    .rd_valid(s_rd_valid), .rd_class(s_rd_class), .rd_data(s_rd_data),
    .rd_err(s_rd_err), .level(s_level), .cnt_sel(cnt_sel),
    .cnt_value(s_cnt_value), .stall_cnt(s_stall_cnt), .clr(clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [15:0] exp);
    cnt_sel = sel;
    #1;
    chk(tag, cnt_value, exp);
  endtask

  initial begin
    rst = 1'b0; out_valid = 0; rd_req = 0; clr = 0;
    out_class = 0; cnt_sel = 0; out_data = 0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: async reset while a pop response is in flight
    out_valid = 1; out_class = 1; out_data = 8'h55;
    tick(); tick();
    out_valid = 0; rd_req = 1;
    tick();
    rd_req = 0;
    chk("pre_rst_rd_valid", rd_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_out_ready", out_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_stall", stall_cnt, 0);
    for (int c = 0; c < 4; c++) chk_cnt("rst_cnt", 2'(c), 0);
    tick();
    rst = 1'b1;
    tick();

    // 2: ordering and per-class counts
    out_valid = 1;
    out_class = 0; out_data = 8'h11; tick();
    out_class = 1; out_data = 8'h22; tick();
    out_class = 3; out_data = 8'h33; tick();
    out_valid = 0;
    chk("ord_level", level, 3);
    for (int i = 0; i < 3; i++) begin
      rd_req = 1;
      chk("ord_no_early_valid", rd_valid, 0);
      tick();
      rd_req = 0;
      chk("ord_valid", rd_valid, 1);
      chk("ord_data", rd_data, 8'h11 * (i + 1));
      tick();
      chk("ord_hold", rd_data, 8'h11 * (i + 1));
    end
    chk("ord_cls_last", rd_class, 3);
    chk_cnt("ord_cnt0", 0, 1);
    chk_cnt("ord_cnt1", 1, 1);
    chk_cnt("ord_cnt2", 2, 0);
    chk_cnt("ord_cnt3", 3, 1);

    // 3: fill, stall, pop at full does not admit a same-cycle write
    out_valid = 1; out_class = 2;
    for (int i = 0; i < 8; i++) begin
      out_data = 8'(i);
      tick();
    end
    chk("full_level", level, 8);
    chk("full_ready", out_ready, 0);
    out_data = 8'hAA;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_cnt5", stall_cnt, 5);
    rd_req = 1;
    tick();
    rd_req = 0;
    chk("full_pop_level", level, 7);
    chk("full_pop_ready", out_ready, 1);
    chk("full_pop_data", rd_data, 8'h00);
    chk("full_pop_stall", stall_cnt, 6);
    tick();
    out_valid = 0;
    chk("refill_level", level, 8);
    rd_req = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_data", rd_data, (i < 7) ? 8'(i + 1) : 8'hAA);
    end
    rd_req = 0;
    chk("drain_level", level, 0);

    // 4: pop on empty
    out_class = 3; out_data = 8'h5A;
    rd_req = 1;
    tick();
    rd_req = 0;
    chk("empty_err", rd_err, 1);
    chk("empty_valid", rd_valid, 0);
    chk("empty_level", level, 0);
    tick();
    chk("empty_err_pulse", rd_err, 0);
    rd_req = 1; out_valid = 1;
    tick();
    rd_req = 0; out_valid = 0;
    chk("empty_wr_err", rd_err, 1);
    chk("empty_wr_valid", rd_valid, 0);
    chk("empty_wr_level", level, 1);
    rd_req = 1;
    tick();
    rd_req = 0;
    chk("empty_wr_pop", rd_data, 8'h5A);
    chk("empty_wr_pop_lvl", level, 0);

    // 5: concurrent write+pop at level 3 with pointer wrap, then clr priority
    out_valid = 1; out_class = 0;
    for (int i = 0; i < 3; i++) begin
      out_data = 8'h40 + 8'(i);
      tick();
    end
    rd_req = 1;
    for (int i = 0; i < 20; i++) begin
      out_data = 8'h43 + 8'(i);
      tick();
      chk("wrap_level", level, 3);
      chk("wrap_data", rd_data, 8'h40 + 8'(i));
    end
    rd_req = 0; out_valid = 0;
    chk_cnt("wrap_cnt0", 0, 24);
    chk_cnt("pre_clr_cnt2", 2, 9);
    out_valid = 1; out_class = 2; out_data = 8'h77; clr = 1;
    tick();
    out_valid = 0; clr = 0;
    chk_cnt("clr_cnt2", 2, 0);
    chk_cnt("clr_cnt0", 0, 0);
    chk("clr_stall", stall_cnt, 0);
    chk("clr_level", level, 4);

    // 6: saturation on the narrow-counter instance
    rst = 0;
    tick();
    rst = 1;
    out_valid = 1; out_class = 1; rd_req = 1;
    for (int i = 0; i < 20; i++) begin
      out_data = 8'(i);
      tick();
    end
    out_valid = 0; rd_req = 0;
    cnt_sel = 1;
    #1;
    chk("sat_cnt_narrow", s_cnt_value, 15);
    chk("sat_cnt_wide", cnt_value, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
